regfile_2r1w_sb: RTL and testbench

Parametrised register file with two read ports and one write port: the next-generation replacement for the 8x16 single-read-port register file in the datapath. Adds configurable width and depth, optional write-to-read bypass, asynchronous reset of all registers, a per-register pending-write scoreboard for multi-cycle producers, and a hardware clear sequencer that zeroes the file one entry per cycle. Sits between the writeback mux and the A/B operand latches.

---
 rtl/regfile_2r1w_sb.sv | 118 +++++++++++
 tb/tb_regfile_2r1w_sb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_sb.sv
// Two-read, one-write register file with per-register pending scoreboard,
// optional write-to-read bypass and a one-entry-per-cycle hardware clear sweep.
module regfile_2r1w_sb #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned AW     = 3,
  parameter bit          BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic             busy_a,
  output logic             busy_b,
  input  logic             reserve,
  input  logic [AW-1:0]    reservenum,
  input  logic             clear_start,
  output logic             clear_busy,
  output logic             clear_done
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] pend_q;
  logic             wr_acc, rsv_acc;

  // Writes and reserves are only honoured while no sweep is running.
  always_comb begin
    wr_acc  = write && (state_q == StIdle);
    rsv_acc = reserve && (state_q == StIdle);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_start) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Reserve is applied after the write so a same-register reserve wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else if (state_q == StClear) begin
      regs_q[cnt_q] <= '0;
      pend_q[cnt_q] <= 1'b0;
    end else begin
      if (wr_acc) begin
        regs_q[writenum] <= data_in;
        pend_q[writenum] <= 1'b0;
      end
      if (rsv_acc) begin
        pend_q[reservenum] <= 1'b1;
      end
    end
  end

  always_comb begin
    data_out_a = regs_q[readnum_a];
    busy_a     = pend_q[readnum_a];
    data_out_b = regs_q[readnum_b];
    busy_b     = pend_q[readnum_b];
    if (BYPASS && wr_acc && (writenum == readnum_a)) begin
      data_out_a = data_in;
      busy_a     = rsv_acc && (reservenum == readnum_a);
    end
    if (BYPASS && wr_acc && (writenum == readnum_b)) begin
      data_out_b = data_in;
      busy_b     = rsv_acc && (reservenum == readnum_b);
    end
  end

  always_comb begin
    clear_busy = (state_q == StClear);
    clear_done = done_q;
  end

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Scoreboard bench: stimulus queues expected outputs, a monitor compares them.
module tb_regfile_2r1w_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] d_in;
  logic [2:0]  wnum, ra, rb, rsvnum;
  logic        wr, rsv, cs;

  logic [15:0] o1a, o1b, o0a, o0b;
  logic        b1a, b1b, b0a, b0b, cb1, cd1, cb0, cd0;

  logic [31:0] w_d, w_oa, w_ob;
  logic [3:0]  w_wnum, w_ra, w_rb, w_rsvnum;
  logic        w_wr, w_rsv, w_cs, w_ba, w_bb, w_cb, w_cd;

  regfile_2r1w_sb #(.WIDTH(16), .AW(3), .BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .data_in(d_in), .writenum(wnum), .write(wr),
    .readnum_a(ra), .readnum_b(rb), .data_out_a(o1a), .data_out_b(o1b),
    .busy_a(b1a), .busy_b(b1b), .reserve(rsv), .reservenum(rsvnum),
    .clear_start(cs), .clear_busy(cb1), .clear_done(cd1)
  );

  regfile_2r1w_sb #(.WIDTH(16), .AW(3), .BYPASS(1'b0)) u_nobyp (
    .clk(clk), .reset(reset), .data_in(d_in), .writenum(wnum), .write(wr),
    .readnum_a(ra), .readnum_b(rb), .data_out_a(o0a), .data_out_b(o0b),
    .busy_a(b0a), .busy_b(b0b), .reserve(rsv), .reservenum(rsvnum),
    .clear_start(cs), .clear_busy(cb0), .clear_done(cd0)
  );

  regfile_2r1w_sb #(.WIDTH(32), .AW(4), .BYPASS(1'b1)) u_wide (
    .clk(clk), .reset(reset), .data_in(w_d), .writenum(w_wnum), .write(w_wr),
    .readnum_a(w_ra), .readnum_b(w_rb), .data_out_a(w_oa), .data_out_b(w_ob),
    .busy_a(w_ba), .busy_b(w_bb), .reserve(w_rsv), .reservenum(w_rsvnum),
    .clear_start(w_cs), .clear_busy(w_cb), .clear_done(w_cd)
  );

  localparam int B1_OA = 0, B1_OB = 1, B1_BA = 2, B1_BB = 3, B1_CB = 4, B1_CD = 5;
  localparam int B0_OA = 6, B0_OB = 7, B0_BA = 8, B0_BB = 9, B0_CB = 10, B0_CD = 11;
  localparam int W_OA = 12, W_OB = 13, W_CB = 14, W_CD = 15, W_LEN = 16;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  event chk_ev;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   wide_len = 0;

  function automatic logic [31:0] act(input int sel);
    case (sel)
      B1_OA:   return {16'h0, o1a};
      B1_OB:   return {16'h0, o1b};
      B1_BA:   return {31'h0, b1a};
      B1_BB:   return {31'h0, b1b};
      B1_CB:   return {31'h0, cb1};
      B1_CD:   return {31'h0, cd1};
      B0_OA:   return {16'h0, o0a};
      B0_OB:   return {16'h0, o0b};
      B0_BA:   return {31'h0, b0a};
      B0_BB:   return {31'h0, b0b};
      B0_CB:   return {31'h0, cb0};
      B0_CD:   return {31'h0, cd0};
      W_OA:    return w_oa;
      W_OB:    return w_ob;
      W_CB:    return {31'h0, w_cb};
      W_CD:    return {31'h0, w_cd};
      W_LEN:   return 32'(wide_len);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: drains every expectation queued before the sample strobe.
  initial begin
    exp_t e;
    logic [31:0] a;
    forever begin
      @(chk_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = act(e.sel);
        tests_run++;
        if (a !== e.val) begin
          tests_failed++;
          $display("FAIL %s: got %h expected %h", e.name, a, e.val);
        end
      end
    end
  end

  task automatic ex(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic sample();
    #1;
    ->chk_ev;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    d_in = '0; wnum = '0; ra = '0; rb = '0; rsvnum = '0; wr = 0; rsv = 0; cs = 0;
    w_d = '0; w_wnum = '0; w_ra = '0; w_rb = '0; w_rsvnum = '0;
    w_wr = 0; w_rsv = 0; w_cs = 0;

    // Reset state on every address
    #2;
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i);
      rb = 3'(7 - i);
      ex("rst_out_a", B1_OA, 0);
      ex("rst_out_b", B1_OB, 0);
      ex("rst_busy_a", B1_BA, 0);
      ex("rst_busy_b", B1_BB, 0);
      ex("rst_clear_busy", B1_CB, 0);
      ex("rst_clear_done", B1_CD, 0);
      sample();
    end
    step();
    reset = 1'b0;

    // Writes, registered reads and bypass
    step(); wr = 1; wnum = 3; d_in = 16'h1234;
    step(); wnum = 5; d_in = 16'hBEEF;
    step(); wr = 0; ra = 3; rb = 5;
    ex("rd_r3", B1_OA, 32'h1234); ex("rd_r5", B1_OB, 32'hBEEF);
    ex("nb_rd_r3", B0_OA, 32'h1234); ex("nb_rd_r5", B0_OB, 32'hBEEF);
    sample();
    wr = 1; wnum = 6; d_in = 16'h00AA; ra = 6;
    ex("bypass_r6", B1_OA, 32'h00AA); ex("nb_old_r6", B0_OA, 0);
    ex("bypass_busy_r6", B1_BA, 0);
    sample();
    step(); wr = 0;
    ex("reg_r6", B1_OA, 32'h00AA); ex("nb_reg_r6", B0_OA, 32'h00AA);
    sample();

    // Reserve / write interplay
    rsv = 1; rsvnum = 2; ra = 2;
    ex("rsv_not_bypassed", B1_BA, 0);
    sample();
    step(); rsv = 0;
    ex("rsv_busy", B1_BA, 1); ex("nb_rsv_busy", B0_BA, 1);
    sample();
    wr = 1; wnum = 2; d_in = 16'h0042;
    ex("wr_clr_busy_byp", B1_BA, 0); ex("wr_byp_data", B1_OA, 32'h0042);
    ex("nb_busy_held", B0_BA, 1); ex("nb_data_old", B0_OA, 0);
    sample();
    step(); wr = 0;
    ex("busy_after_wr", B1_BA, 0); ex("nb_busy_after_wr", B0_BA, 0);
    ex("data_after_wr", B1_OA, 32'h0042);
    sample();
    rsv = 1; rsvnum = 4; wr = 1; wnum = 4; d_in = 16'h0777; rb = 4;
    ex("rsvwr_busy_byp", B1_BB, 1); ex("rsvwr_data_byp", B1_OB, 32'h0777);
    sample();
    step(); rsv = 0; wr = 0;
    ex("rsvwr_busy", B1_BB, 1); ex("rsvwr_data", B1_OB, 32'h0777);
    ex("nb_rsvwr_busy", B0_BB, 1); ex("nb_rsvwr_data", B0_OB, 32'h0777);
    sample();

    // Fill, reserve R1, then clear sweep
    for (int i = 0; i < 8; i++) begin
      step(); wr = 1; wnum = 3'(i); d_in = 16'hFFFF;
    end
    step(); wr = 0; rsv = 1; rsvnum = 1;
    step(); rsv = 0; ra = 1; cs = 1;
    ex("pre_clr_busy_r1", B1_BA, 1); ex("pre_clr_clear_busy", B1_CB, 0);
    sample();
    step();
    for (int k = 0; k < 8; k++) begin
      ra = 3'(k); rb = 3'(k - 1);
      wr = 1; wnum = 3'(k); d_in = 16'h1111;
      rsv = 1; rsvnum = 3'(k); cs = 1;
      ex("sweep_clear_busy", B1_CB, 1); ex("sweep_clear_done", B1_CD, 0);
      ex("sweep_uncleared", B1_OA, 32'hFFFF);
      ex("sweep_cleared", B1_OB, (k == 0) ? 32'hFFFF : 32'h0);
      ex("sweep_busy", B1_BA, (k == 1) ? 32'h1 : 32'h0);
      sample();
      step();
    end
    cs = 0; rsv = 0; wr = 1; wnum = 0; d_in = 16'h0BAD; ra = 0;
    ex("done_pulse", B1_CD, 1); ex("nb_done_pulse", B0_CD, 1);
    ex("done_not_busy", B1_CB, 0); ex("wr_at_done_byp", B1_OA, 32'h0BAD);
    sample();
    step(); wr = 0;
    ex("done_one_cycle", B1_CD, 0);
    sample();
    for (int i = 0; i < 8; i++) begin
      ra = 3'(i); rb = 3'(i);
      ex("post_clr_a", B1_OA, (i == 0) ? 32'h0BAD : 32'h0);
      ex("post_clr_busy", B1_BA, 0);
      ex("nb_post_clr_b", B0_OB, (i == 0) ? 32'h0BAD : 32'h0);
      sample();
    end

    // Reset in the middle of a sweep
    step(); wr = 1; wnum = 5; d_in = 16'hABCD;
    step(); wr = 0; cs = 1;
    step(); cs = 0;
    step();
    step(); ra = 5; rb = 0;
    ex("mid_clr_r5", B1_OA, 32'hABCD); ex("mid_clr_busy", B1_CB, 1);
    sample();
    reset = 1;
    ex("arst_r5", B1_OA, 0); ex("arst_clear_busy", B1_CB, 0);
    ex("arst_nb_clear_busy", B0_CB, 0); ex("arst_busy_a", B1_BA, 0);
    ex("arst_out_b", B1_OB, 0);
    sample();
    step(); reset = 0;
    for (int i = 0; i < 12; i++) begin
      ex("abort_no_done", B1_CD, 0); ex("abort_idle", B1_CB, 0);
      sample();
      step();
    end
    wr = 1; wnum = 7; d_in = 16'h5555;
    step(); wr = 0; ra = 7;
    ex("post_rst_wr", B1_OA, 32'h5555); ex("nb_post_rst_wr", B0_OA, 32'h5555);
    sample();

    // Wide instance
    step(); w_wr = 1; w_wnum = 15; w_d = 32'hDEADBEEF; w_ra = 15; w_rb = 15;
    ex("wide_byp_a", W_OA, 32'hDEADBEEF);
    sample();
    step(); w_wr = 0;
    ex("wide_rd_a", W_OA, 32'hDEADBEEF); ex("wide_rd_b", W_OB, 32'hDEADBEEF);
    sample();
    w_cs = 1;
    step(); w_cs = 0;
    wide_len = 0;
    while (w_cb && wide_len < 40) begin
      wide_len++;
      step();
    end
    ex("wide_clear_len", W_LEN, 16); ex("wide_done", W_CD, 1);
    ex("wide_cleared", W_OA, 0); ex("wide_idle", W_CB, 0);
    sample();

    step();
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
